// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
//   Shared definitions for the load/store initiator:
//     size_e        - request size encodings (byte / half / word / illegal)
//     state_e       - initiator FSM states
//     DATA_WIDTH    - fixed data-bus width of the memory port
//     is_misaligned - predicate deciding whether a request may touch memory
// -----------------------------------------------------------------------------
package mem_access_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  // A request is rejected (no memory access, misaligned response) when the
  // low address bits do not fit its natural alignment, or the size is illegal.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lane);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lane[0];
      SIZE_WORD: mis = (lane != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational little-endian lane logic shared by the load path and
//   the read-modify-write store path.
//   Ports:
//     size       in  2   request size (size_e encoding)
//     sign_ext   in  1   1 = sign-extend sub-word loads
//     lane       in  2   byte offset inside the word (addr[1:0])
//     mem_word   in  32  word read from memory
//     wdata      in  32  right-justified store data
//     load_data  out 32  addressed lane shifted to bit 0 and extended
//     merge_data out 32  mem_word with addressed lane(s) replaced by wdata
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [1:0]            lane,
  input  logic [DATA_WIDTH-1:0] mem_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load extract
  always_comb begin
    byte_sel = mem_word[7:0];
    case (lane)
      2'd0:    byte_sel = mem_word[7:0];
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      default: byte_sel = mem_word[31:24];
    endcase

    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:   load_data = mem_word;
    endcase
  end

  // Store merge: keep the captured word, overwrite only the addressed lane(s).
  // A word store replaces everything, so the captured word is irrelevant there.
  always_comb begin
    merge_data = mem_word;
    case (size)
      SIZE_BYTE: begin
        case (lane)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (lane[1]) merge_data[31:16] = wdata[15:0];
        else         merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store initiator between the pipeline memory stage and port 2 of the
//   word-wide MEMORY block. One request at a time; sub-word stores are done as
//   read-modify-write.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     req_valid/req_ready     request handshake (accept on valid && ready)
//     req_write               1 = store, 0 = load
//     req_size                00 byte, 01 half, 10 word, 11 illegal
//     req_signed              sign-extend sub-word loads
//     req_addr                byte address
//     req_wdata               right-justified store data
//     resp_valid              one-cycle response pulse, no backpressure
//     resp_rdata              load result (0 for stores / misaligned)
//     resp_misaligned         request rejected, no memory access made
//     memory_write_enable2    port-2 write strobe
//     memory_address2         word-aligned port-2 address
//     memory_data2            bidirectional data, driven only while writing
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic                  memory_write_enable2,
  output logic [ADDR_WIDTH-1:0] memory_address2,
  inout  wire  [DATA_WIDTH-1:0] memory_data2
);

  state_e state_q, state_d;

  // Request latch and read-data capture; these carry no reset because every
  // output that depends on them is gated by the FSM state.
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [1:0]            size_q,   size_d;
  logic                  signed_q, signed_d;
  logic                  write_q,  write_d;
  logic                  mis_q,    mis_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [DATA_WIDTH-1:0] rword_q,  rword_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  assign accept = req_valid && (state_q == IDLE);

  mem_lane_align u_align (
    .size       (size_q),
    .sign_ext   (signed_q),
    .lane       (addr_q[1:0]),
    .mem_word   (rword_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_misaligned(req_size, req_addr[1:0]))
            state_d = RESP;
          else if (req_write && (req_size == SIZE_WORD))
            state_d = WRITE;
          else
            state_d = READ;  // loads, and the read half of a sub-word RMW
        end
      end
      READ:    state_d = write_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch / capture next values
  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    mis_d    = mis_q;
    wdata_d  = wdata_q;
    rword_d  = rword_q;
    if (accept) begin
      addr_d   = req_addr;
      size_d   = req_size;
      signed_d = req_signed;
      write_d  = req_write;
      mis_d    = is_misaligned(req_size, req_addr[1:0]);
      wdata_d  = req_wdata;
    end
    // The memory drives the bus throughout READ; sample it at the end.
    if (state_q == READ) begin
      rword_d = memory_data2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    size_q   <= size_d;
    signed_q <= signed_d;
    write_q  <= write_d;
    mis_q    <= mis_d;
    wdata_q  <= wdata_d;
    rword_q  <= rword_d;
  end

  // Outputs are decoded straight from the state register so that an
  // asynchronous reset forces them to their idle values immediately.
  assign req_ready            = (state_q == IDLE);
  assign resp_valid           = (state_q == RESP);
  assign resp_misaligned      = resp_valid && mis_q;
  assign resp_rdata           = (resp_valid && !write_q && !mis_q) ? load_data : '0;
  assign memory_write_enable2 = (state_q == WRITE);
  assign memory_address2      = ((state_q == READ) || (state_q == WRITE)) ?
                                {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;

  // For word stores the merge path returns wdata unchanged.
  assign memory_data2 = memory_write_enable2 ? merge_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int AW = 32;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_misaligned;
  logic          memory_write_enable2;
  logic [AW-1:0] memory_address2;
  wire  [31:0]   memory_data2;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_write            (req_write),
    .req_size             (req_size),
    .req_signed           (req_signed),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .resp_valid           (resp_valid),
    .resp_rdata           (resp_rdata),
    .resp_misaligned      (resp_misaligned),
    .memory_write_enable2 (memory_write_enable2),
    .memory_address2      (memory_address2),
    .memory_data2         (memory_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide memory model: combinational read onto the bus while not
  // writing, write committed on posedge when the strobe is high.
  logic [31:0] mem [0:15];
  logic        mem_init;

  assign memory_data2 = memory_write_enable2 ? 32'bz : mem[memory_address2[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int n = 0; n < 16; n++) mem[n] <= {16'(n), 16'(n)};
    end else if (memory_write_enable2) begin
      mem[memory_address2[5:2]] <= memory_data2;
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic [31:0] exp_bus;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } resp_t;

  resp_t sb[$];
  vec_t  vecs[$];
  int    checks;
  int    errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_mis,
                              input logic [31:0] exp_bus, input int exp_lat);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_mis = exp_mis; v.exp_bus = exp_bus; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Drive one request, then keep req_valid high with a junk store to word 2
  // while the block is busy; that junk must never be accepted.
  task automatic run_vec(input vec_t v, input string tag);
    int    lat;
    int    we_cnt;
    bit    done;
    resp_t e;
    resp_t r;
    lat = 0; we_cnt = 0; done = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
    chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    e.rdata = v.exp_rdata;
    e.mis   = v.exp_mis;
    sb.push_back(e);
    #1;
    req_write  = 1'b1;
    req_size   = SIZE_WORD;
    req_signed = 1'b1;
    req_addr   = 32'h8;
    req_wdata  = 32'hFFFF_FFFF;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      if (memory_write_enable2) begin
        we_cnt++;
        chk({tag, " bus"}, memory_data2, v.exp_bus);
        chk({tag, " addr"}, memory_address2, {v.addr[31:2], 2'b00});
      end
      if (resp_valid) begin
        done = 1'b1;
        req_valid = 1'b0;
        if (sb.size() != 0) begin
          r = sb.pop_front();
          chk({tag, " rdata"}, resp_rdata, r.rdata);
          chk({tag, " misaligned"}, 32'(resp_misaligned), 32'(r.mis));
        end else begin
          chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end
      end else begin
        lat++;
      end
    end
    req_valid = 1'b0;
    chk({tag, " resp_seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " we_cycles"}, 32'(we_cnt), (v.wr && !v.exp_mis) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, " resp_drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;

    // wr size sgn addr wdata | exp_rdata mis exp_bus lat
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'h8, 0,            32'h0002_0002, 0, 0,             1));
    vecs.push_back(mk(1, SIZE_BYTE, 0, 32'h5, 32'h0000_00AB, 32'h0,        0, 32'h0001_AB01, 2));
    vecs.push_back(mk(0, SIZE_BYTE, 1, 32'h5, 0,            32'hFFFF_FFAB, 0, 0,             1));
    vecs.push_back(mk(0, SIZE_BYTE, 0, 32'h5, 0,            32'h0000_00AB, 0, 0,             1));
    vecs.push_back(mk(1, SIZE_WORD, 0, 32'h4, 32'h0123_4567, 32'h0,        0, 32'h0123_4567, 1));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'h4, 0,            32'h0123_4567, 0, 0,             1));
    vecs.push_back(mk(1, SIZE_WORD, 0, 32'h4, 32'h89AB_CDEF, 32'h0,        0, 32'h89AB_CDEF, 1));
    vecs.push_back(mk(0, SIZE_HALF, 1, 32'h6, 0,            32'hFFFF_89AB, 0, 0,             1));
    vecs.push_back(mk(0, SIZE_HALF, 0, 32'h4, 0,            32'h0000_CDEF, 0, 0,             1));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'h6, 0,            32'h0,         1, 0,             0));
    vecs.push_back(mk(1, SIZE_HALF, 0, 32'h3, 32'h0000_5555, 32'h0,        1, 0,             0));
    vecs.push_back(mk(1, 2'b11,     0, 32'h0, 32'hFFFF_FFFF, 32'h0,        1, 0,             0));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'h4, 0,            32'h89AB_CDEF, 0, 0,             1));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'h0, 0,            32'h0,         0, 0,             1));
    vecs.push_back(mk(1, SIZE_HALF, 0, 32'hE, 32'h1234_BEEF, 32'h0,        0, 32'hBEEF_0003, 2));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'hC, 0,            32'hBEEF_0003, 0, 0,             1));
    vecs.push_back(mk(0, SIZE_BYTE, 1, 32'hF, 0,            32'hFFFF_FFBE, 0, 0,             1));
    vecs.push_back(mk(0, SIZE_BYTE, 0, 32'hC, 0,            32'h0000_0003, 0, 0,             1));
    vecs.push_back(mk(0, SIZE_HALF, 1, 32'hC, 0,            32'h0000_0003, 0, 0,             1));
    vecs.push_back(mk(1, SIZE_BYTE, 0, 32'h3, 32'h0000_0080, 32'h0,        0, 32'h8000_0000, 2));
    vecs.push_back(mk(0, SIZE_BYTE, 1, 32'h3, 0,            32'hFFFF_FF80, 0, 0,             1));
    vecs.push_back(mk(0, SIZE_WORD, 0, 32'h8, 0,            32'h0002_0002, 0, 0,             1));

    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_misaligned", 32'(resp_misaligned), 32'd0);
    chk("reset we", 32'(memory_write_enable2), 32'd0);
    chk("reset address", memory_address2, 32'd0);
    @(negedge clk);
    mem_init = 1'b0;
    rst_n = 1'b1;

    // Reset pulsed during the WRITE cycle of a word store to 0x8.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    chk("midwrite we_high", 32'(memory_write_enable2), 32'd1);
    chk("midwrite bus", memory_data2, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    chk("midwrite we_drop", 32'(memory_write_enable2), 32'd0);
    chk("midwrite ready", 32'(req_ready), 32'd1);
    chk("midwrite address", memory_address2, 32'd0);
    chk("midwrite resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(0, SIZE_WORD, 0, 32'h8, 0, 32'h0002_0002, 0, 0, 1), "after_reset_load");

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the pipeline's memory stage and port 2 of the MEMORY block. It accepts one byte, halfword or word request at a time and drives the port-2 write-enable, address and bidirectional data bus. Sub-word stores are performed as read-modify-write on the word-wide memory. The block returns aligned, sign- or zero-extended load data, or a misalignment flag.

## Interface
- ADDR_WIDTH, 32, byte-address width; data width is fixed at 32.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  block can accept a request (reset 1).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse (reset 0).
- resp_rdata  out  32  load result; 0 for stores and errors (reset 0).
- resp_misaligned  out  1  valid with resp_valid (reset 0).
- memory_write_enable2  out  1  port-2 write strobe (reset 0).
- memory_address2  out  ADDR_WIDTH  word-aligned address, req_addr & ~3 (reset 0).
- memory_data2  inout  32  driven only while writing, otherwise high-Z (high-Z in reset).

## Operation
- A request is accepted on a posedge where req_valid && req_ready. The block latches addr, size, signed, write and wdata.
- Lanes are little-endian. The byte lane is addr[1:0]. The half lane is addr[1] (0 = bits 15:0).
- Misaligned cases: size 01 with addr[0]=1, size 10 with addr[1:0]≠0, or size 11. In all of these there is no memory access and the response carries resp_misaligned=1.
- States:
  - IDLE: ready=1.
  - READ: we=0, address driven; read data is captured at the end of the cycle.
  - WRITE: we=1, address and merged data driven; memory commits at the end of the cycle.
  - RESP: resp_valid=1.
- Transitions out of IDLE on accept:
  - Misaligned → RESP.
  - Any load → READ.
  - Word store → WRITE.
  - Byte or half store → READ.
- READ → WRITE for a sub-word store. READ → RESP for a load.
- WRITE → RESP. RESP → IDLE.
- Store merge: the captured word is kept, and only the addressed lane(s) are replaced by the low bits of wdata.
- Load extract: the addressed lane is shifted to bit 0, then extended with bit 7 or bit 15 when signed, else zeros. Word loads pass through unchanged.
- The response has no backpressure; the pipeline must take resp_valid in its cycle.
- req_ready is 0 outside IDLE. Inputs presented then are ignored.

## Timing
- Let the accept edge be E0.
  - Load: READ in cycle E0–E1, RESP in E1–E2, ready again after E2. Throughput is 3 cycles.
  - Word store: WRITE in E0–E1, RESP in E1–E2. Throughput is 3 cycles.
  - Sub-word store: READ, WRITE, RESP. Throughput is 4 cycles.
  - Misaligned: RESP in E0–E1. Throughput is 2 cycles.
- memory_write_enable2 and memory_data2 are asserted/driven for exactly one cycle per store. They are never asserted during READ, IDLE or RESP.
- Asserting rst_n low at any time immediately forces IDLE and we=0, releases the bus to Z, and sets all outputs to reset values. A WRITE cycle interrupted before its posedge must not modify memory.
- No request is pending after reset.

## Structure
- Package mem_access_pkg:
  - Size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - State enum IDLE/READ/WRITE/RESP.
  - Misalignment predicate function.
- Sub-module mem_lane_align: purely combinational lane extract/extend and lane merge. It is shared by the load path and the RMW path.
- The top level holds the FSM, the request latch, the read-data capture register and the tristate driver.

## Test plan
Memory is initialised with word n at byte address 4n = {n[15:0], n[15:0]}.
- Word load at 0x8 → resp_valid 2 cycles after accept, rdata 0x00020002, misaligned 0, we never high.
- Word store 0x01234567 at 0x4, then word load at 0x4 → we high for one cycle with bus = 0x01234567; load returns 0x01234567; bus is Z in every other cycle.
- Byte store 0xAB at 0x5 on fresh memory → READ then WRITE of 0x0001AB01. Signed byte load at 0x5 → 0xFFFFFFAB; unsigned → 0x000000AB.
- Word store 0x89ABCDEF at 0x4 → signed half load at 0x6 returns 0xFFFF89AB; unsigned half load at 0x4 returns 0x0000CDEF.
- Word load at 0x6, half store at 0x3, and size 11 at 0x0 → each returns resp_valid one cycle after accept with misaligned=1 and rdata=0. we stays 0 and memory is unchanged.
- rst_n pulsed low mid-WRITE of a store to 0x8 → we and bus drop asynchronously, req_ready=1, and a later load of 0x8 returns 0x00020002.
